// File: rtl/led_trail_pwm.sv
// Output stage for the red/green scrolling LED bars: a per-LED intensity level
// that loads on a lit bit, decays one step per decay tick, and drives a shared PWM.
module led_trail_pwm #(
    parameter int PWM_BITS  = 4,
    parameter int DECAY_DIV = 2500000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          in_red,
    input  logic [7:0]          in_green,
    input  logic [PWM_BITS-1:0] brightness,
    output logic [7:0]          led_red,
    output logic [7:0]          led_green
);

    localparam int DIV_W = (DECAY_DIV > 2) ? $clog2(DECAY_DIV) : 1;
    localparam logic [DIV_W-1:0]    DIV_LAST  = DIV_W'(DECAY_DIV - 1);
    localparam logic [DIV_W-1:0]    DIV_ZERO  = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0]    DIV_ONE   = DIV_W'(1);
    localparam logic [PWM_BITS-1:0] LVL_ZERO  = {PWM_BITS{1'b0}};
    localparam logic [PWM_BITS-1:0] LVL_ONE   = PWM_BITS'(1);

    // Channel index 0..7 is red, 8..15 is green.
    logic [15:0]         sync1_r;
    logic [15:0]         sync2_r;
    logic [DIV_W-1:0]    presc_r;
    logic [PWM_BITS-1:0] pwm_cnt_r;
    logic [PWM_BITS-1:0] level_r     [16];
    logic [PWM_BITS-1:0] level_nxt_s [16];
    logic [15:0]         out_r;
    logic [15:0]         out_nxt_s;
    logic                decay_tick_s;

    assign decay_tick_s = (presc_r == DIV_LAST);
    assign led_red      = out_r[7:0];
    assign led_green    = out_r[15:8];

    // Two-flop synchroniser for the asynchronous scroll patterns.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r <= 16'h0000;
            sync2_r <= 16'h0000;
        end else begin
            sync1_r <= {in_green, in_red};
            sync2_r <= sync1_r;
        end
    end

    // Decay prescaler and free-running PWM slot counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_r   <= DIV_ZERO;
            pwm_cnt_r <= LVL_ZERO;
        end else begin
            if (decay_tick_s) begin
                presc_r <= DIV_ZERO;
            end else begin
                presc_r <= presc_r + DIV_ONE;
            end
            pwm_cnt_r <= pwm_cnt_r + LVL_ONE;
        end
    end

    // Next level: a lit bit loads brightness and beats a coincident decay tick.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            level_nxt_s[i] = level_r[i];
            if (sync2_r[i]) begin
                level_nxt_s[i] = brightness;
            end else if (decay_tick_s && (level_r[i] != LVL_ZERO)) begin
                level_nxt_s[i] = level_r[i] - LVL_ONE;
            end else begin
                level_nxt_s[i] = level_r[i];
            end
        end
    end

    // Per-channel intensity registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) begin
                level_r[i] <= LVL_ZERO;
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                level_r[i] <= level_nxt_s[i];
            end
        end
    end

    // PWM compare: level L is on during slots 0..L-1.
    always_comb begin
        out_nxt_s = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            out_nxt_s[i] = (level_r[i] > pwm_cnt_r);
        end
    end

    // Registered LED drive; cleared asynchronously so reset blanks the bars at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_r <= 16'h0000;
        end else begin
            out_r <= out_nxt_s;
        end
    end

endmodule

// File: tb/tb_led_trail_pwm.sv
// Self-checking bench for led_trail_pwm: duty table, directed corner sequences,
// and randomized patterns against a cycle-indexed reference model.
module tb_led_trail_pwm;

    logic       clk;
    logic       reset;
    logic [7:0] in_red;
    logic [7:0] in_green;
    logic [3:0] brightness;
    logic [7:0] led_red;
    logic [7:0] led_green;

    led_trail_pwm #(.PWM_BITS(4), .DECAY_DIV(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_red    (in_red),
        .in_green  (in_green),
        .brightness(brightness),
        .led_red   (led_red),
        .led_green (led_green)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: edge count since reset release gives pwm slot and tick phase.
    int          m_level [16];
    logic [15:0] m_s1;
    logic [15:0] m_s2;
    logic [15:0] m_out;
    int          m_n;
    int          hi_cnt  [16];

    typedef struct {
        logic [7:0] red;
        logic [7:0] green;
        logic [3:0] bright;
        int         duty;
    } vec_t;
    vec_t vecs [5];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_level[i] = 0;
        m_s1  = 16'h0000;
        m_s2  = 16'h0000;
        m_out = 16'h0000;
        m_n   = 0;
    endtask

    // One clock: advance the model with pre-edge values, then compare the outputs.
    task automatic tick();
        int   pwm;
        logic tk;
        @(posedge clk);
        if (reset) begin
            pwm = m_n % 16;
            tk  = ((m_n % 4) == 3);
            for (int i = 0; i < 16; i++) m_out[i] = (m_level[i] > pwm);
            for (int i = 0; i < 16; i++) begin
                if (m_s2[i]) m_level[i] = int'(brightness);
                else if (tk && m_level[i] > 0) m_level[i] = m_level[i] - 1;
            end
            m_s2 = m_s1;
            m_s1 = {in_green, in_red};
            m_n++;
        end
        #1;
        check("led_cycle", int'({led_green, led_red}), int'(m_out));
        for (int i = 0; i < 16; i++) hi_cnt[i] += int'(m_out[i]);
    endtask

    task automatic clear_hi();
        for (int i = 0; i < 16; i++) hi_cnt[i] = 0;
    endtask

    task automatic async_reset();
        #2;
        reset = 1'b0;
        #1;
        check("reset_immediate", int'({led_green, led_red}), 0);
        model_reset();
    endtask

    initial begin
        logic [15:0] pat;
        int          guard;
        int          sum;

        vecs[0] = '{red: 8'h01, green: 8'h00, bright: 4'd15, duty: 15};
        vecs[1] = '{red: 8'h01, green: 8'h00, bright: 4'd4,  duty: 4};
        vecs[2] = '{red: 8'hA5, green: 8'h3C, bright: 4'd9,  duty: 9};
        vecs[3] = '{red: 8'hFF, green: 8'hFF, bright: 4'd0,  duty: 0};
        vecs[4] = '{red: 8'h00, green: 8'h81, bright: 4'd1,  duty: 1};

        reset      = 1'b0;
        in_red     = 8'h00;
        in_green   = 8'h00;
        brightness = 4'd15;
        model_reset();
        clear_hi();
        #1;
        check("reset_state", int'({led_green, led_red}), 0);
        repeat (3) tick();

        // First high appears three edges after the input change.
        in_red = 8'h01;
        #1;
        reset = 1'b1;
        tick(); check("latency_k0", int'(led_red[0]), 0);
        tick(); check("latency_k1", int'(led_red[0]), 0);
        tick(); check("latency_k2", int'(led_red[0]), 0);
        tick(); check("latency_k3", int'(led_red[0]), 1);

        // Duty table: every channel's on-count over one PWM period.
        for (int r = 0; r < 5; r++) begin
            in_red     = vecs[r].red;
            in_green   = vecs[r].green;
            brightness = vecs[r].bright;
            repeat (64) tick();
            clear_hi();
            repeat (16) tick();
            pat = {vecs[r].green, vecs[r].red};
            for (int i = 0; i < 16; i++) begin
                check($sformatf("duty_v%0d_ch%0d", r, i), hi_cnt[i],
                      pat[i] ? vecs[r].duty : 0);
            end
        end

        // Full brightness: low only in the slot after pwm 15, i.e. 60 of 64 cycles.
        in_red = 8'h01; in_green = 8'h00; brightness = 4'd15;
        repeat (8) tick();
        clear_hi();
        repeat (64) tick();
        check("full_64", hi_cnt[0], 60);

        // Trail on green7: fade to dark after 15 ticks.
        in_red = 8'h00; in_green = 8'h80; brightness = 4'd15;
        repeat (8) tick();
        in_green = 8'h00;
        repeat (8) tick();
        clear_hi();
        repeat (16) tick();
        sum = hi_cnt[15];
        check("trail_partial", int'(sum > 0 && sum < 15), 1);
        repeat (48) tick();
        clear_hi();
        repeat (32) tick();
        check("trail_dark", hi_cnt[15], 0);

        // Load vs decay collision on red3 at brightness 9.
        brightness = 4'd9;
        in_red = 8'h08;
        repeat (4) tick();
        in_red = 8'h00;
        guard = 0;
        while ((m_n % 16) != 5 && guard < 40) begin
            tick();
            guard++;
        end
        check("collision_align", int'(guard < 40), 1);
        in_red = 8'h08;
        tick();
        in_red = 8'h00;
        repeat (3) tick();
        check("collision_level9", int'(led_red[3]), 1);

        // Reset at an arbitrary phase with everything lit.
        in_red = 8'hFF; in_green = 8'hFF; brightness = 4'd15;
        repeat (11) tick();
        async_reset();
        repeat (3) tick();
        check("reset_hold", int'({led_green, led_red}), 0);
        #1;
        reset = 1'b1;

        // Reset mid-fade at level 7; no trail survives.
        in_red = 8'h00; in_green = 8'h80;
        repeat (8) tick();
        in_green = 8'h00;
        guard = 0;
        while (m_level[15] != 7 && guard < 100) begin
            tick();
            guard++;
        end
        check("fade_reach7", int'(guard < 100), 1);
        async_reset();
        repeat (2) tick();
        #1;
        reset = 1'b1;
        clear_hi();
        repeat (40) tick();
        sum = 0;
        for (int i = 0; i < 16; i++) sum += hi_cnt[i];
        check("post_reset_dark", sum, 0);

        // Restart phase: a lit bit right after release shows pwm restarted at 0.
        in_red = 8'h10; brightness = 4'd2;
        repeat (40) tick();

        // Randomized patterns and occasional brightness changes.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(3, 0) == 0) begin
                in_red   = 8'($urandom);
                in_green = 8'($urandom);
            end
            if ($urandom_range(31, 0) == 0) brightness = 4'($urandom);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/led_trail_pwm.md
# led_trail_pwm

Downstream output stage for the scrolling red/green LED bars: consumes the two 8-bit scroll patterns and drives the 16 LED pins. Each LED has its own intensity level. The level is set by a global brightness input while the pattern bit is lit, and it decays one step per decay tick after the bit goes dark, leaving a fading trail behind the scrolling dot. Intensity is rendered by a free-running PWM counter shared by all 16 LEDs.

## Interface

Parameters:
- PWM_BITS, 4, width of the PWM counter and of each intensity level; 2^PWM_BITS PWM slots per period.
- DECAY_DIV, 2500000, decay period in clk cycles (50 ms at 50 MHz); must be >= 2.

Ports:
- clk  in  1  system clock; the only clock in the block.
- reset  in  1  asynchronous, active-low reset.
- in_red  in  8  red scroll pattern; bit = 1 means lit. Asynchronous to clk.
- in_green  in  8  green scroll pattern; same rules as in_red.
- brightness  in  PWM_BITS  target level for lit LEDs. Quasi-static, used directly without synchronisation.
- led_red  out  8  PWM-modulated red LED drive, registered.
- led_green  out  8  PWM-modulated green LED drive, registered.

## Operation

- Input sync: in_red and in_green each pass through a 2-flop synchroniser (sync1 -> sync2). Only sync2 is used downstream.
- Decay prescaler: counts 0..DECAY_DIV-1 and wraps. decay_tick is high for exactly one cycle, while the count equals DECAY_DIV-1.
- PWM counter: free-running, PWM_BITS wide, counts 0..2^PWM_BITS-1 and wraps to 0. Shared by all 16 channels.
- Per-channel level, 16 independent registers, updated every cycle with this priority:
  1. sync2 bit = 1: level <= brightness. This happens every cycle, so level tracks brightness changes while the bit is lit.
  2. Otherwise, decay_tick = 1 and level > 0: level <= level - 1.
  3. Otherwise, level holds.
- Level saturates at 0; it never wraps below 0.
- Output: led bit <= (level > pwm_cnt), using the values held before the edge.
  - Level 0 is always off.
  - Level L is on for exactly L of every 2^PWM_BITS cycles.
  - Maximum level gives (2^PWM_BITS-1)/2^PWM_BITS duty.
- Channel mapping: red channel i maps in_red[i] to led_red[i]; green is identical. Red and green share the decay_tick and pwm_cnt.

## Timing

- Reset values (applied asynchronously while reset = 0): sync registers 0, all levels 0, prescaler 0, pwm_cnt 0, led_red = 8'h00, led_green = 8'h00.
- First edge after reset release: all counters start from 0. pwm_cnt = 0 during the first post-reset cycle.
- Latency from an input bit change (setup met at edge k):
  - sync1 updates at edge k, sync2 at k+1, level at k+2.
  - The output first reflects the new level at edge k+3.
- Simultaneous lit input and decay_tick: the load wins; level = brightness, with no decrement.
- Brightness changes: a lit channel follows at the next edge (output reflects it one edge later). Dark channels keep decaying from their current level; brightness does not rescale them.
- brightness = 0: lit channels load 0, so their outputs are off.
- Full fade time from level L: exactly L decay ticks, i.e. L*DECAY_DIV cycles ± DECAY_DIV depending on tick phase.
- Reset asserted mid-fade: outputs go to 0 immediately, without waiting for a clock edge, and levels are cleared. After release, no residual trail.

## Test plan

Bench parameters: PWM_BITS = 4, DECAY_DIV = 4.

- Reset: drive patterns 8'hFF, brightness 15, assert reset at an arbitrary phase -> led_red and led_green read 8'h00 within the same delta, with no clock edge needed. They stay 0 while reset = 0.
- Full brightness: in_red = 8'h01, brightness = 15, held 64 cycles -> led_red[0] high 15 of every 16 cycles, low exactly in the slot following pwm_cnt = 15. led_red[7:1] and led_green stay 0. First high appears 3 edges after the input change.
- Dimmed: same as above with brightness = 4 -> led_red[0] high exactly 4 of every 16 cycles, in the slots for pwm_cnt 0..3.
- Trail: in_green = 8'h80 at brightness 15 until level settles, then in_green = 8'h00 -> level[green7] steps 15, 14, ..., 0, one step per decay_tick (every 4 cycles). Duty follows the level each period. led_green[7] is constant 0 after 15 ticks.
- Load vs decay collision: toggle in_red[3] so sync2 is 1 exactly on a decay_tick cycle, at brightness 9 -> level = 9 after that edge, not 8.
- Reset mid-fade: start a trail from level 15, assert reset at level 7, release 2 cycles later with inputs 0 -> all outputs 0 and remain 0. The prescaler and pwm_cnt restart from 0.
